// File: rtl/bnn_layer_seq_if.sv
// Handshake and load bus for the sequential binary-neuron layer.
interface bnn_layer_seq_if #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 6
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_INPUTS-1:0]  in_data;
  logic                   load_en;
  logic                   load_sel;
  logic [NUM_INPUTS-1:0]  load_data;
  logic                   out_valid;
  logic [NUM_NEURONS-1:0] out_data;
  logic                   busy;

  // Driver side: offers vectors and loads, observes results.
  modport master (
    output in_valid, in_data, load_en, load_sel, load_data,
    input  in_ready, out_valid, out_data, busy
  );

  // Layer side.
  modport slave (
    input  in_valid, in_data, load_en, load_sel, load_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/bnn_layer_seq.sv
// Binary neural network layer evaluated one neuron per cycle.
// Activation k = popcount(input XNOR weight[k]) >= threshold[k].
module bnn_layer_seq #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 6,
  parameter int THR_INIT    = 2
) (
  input  logic               clk,
  input  logic               reset,
  bnn_layer_seq_if.slave     bus
);
  localparam int THR_W = $clog2(NUM_INPUTS + 1);
  localparam int K_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned NI = NUM_INPUTS;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [K_W-1:0]         wptr_q, wptr_d;
  logic [K_W-1:0]         tptr_q, tptr_d;
  logic [NUM_INPUTS-1:0]  in_reg_q, in_reg_d;
  logic [NUM_NEURONS-1:0] stage_q, stage_d;
  logic [NUM_NEURONS-1:0] out_data_q, out_data_d;
  logic [NUM_INPUTS-1:0]  weight_q [NUM_NEURONS];
  logic [NUM_INPUTS-1:0]  weight_d [NUM_NEURONS];
  logic [THR_W-1:0]       thr_q    [NUM_NEURONS];
  logic [THR_W-1:0]       thr_d    [NUM_NEURONS];

  logic [NUM_INPUTS-1:0]  match;
  logic [THR_W-1:0]       sum;
  logic                   fire;

  assign bus.in_ready  = (state_q == IDLE) && !bus.load_en;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_data_q;

  // Popcount of agreeing bits for the neuron currently being evaluated.
  always_comb begin
    match = ~(in_reg_q ^ weight_q[k_q]);
    sum   = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      sum = sum + THR_W'(match[i]);
    end
    fire = (sum >= thr_q[k_q]);
  end

  // Next-state, load handling and neuron sequencing.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wptr_d     = wptr_q;
    tptr_d     = tptr_q;
    in_reg_d   = in_reg_q;
    stage_d    = stage_q;
    out_data_d = out_data_q;
    weight_d   = weight_q;
    thr_d      = thr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.load_en) begin
          if (bus.load_sel) begin
            thr_d[tptr_q] = bus.load_data[THR_W-1:0];
            tptr_d        = (tptr_q == K_LAST) ? '0 : tptr_q + 1'b1;
          end else begin
            weight_d[wptr_q] = bus.load_data;
            wptr_d           = (wptr_q == K_LAST) ? '0 : wptr_q + 1'b1;
          end
        end else if (bus.in_valid) begin
          in_reg_d = bus.in_data;
          k_d      = '0;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        stage_d[k_q] = fire;
        // The last neuron's bit is merged combinationally so the result
        // register sees the complete vector on the same edge.
        if (k_q == K_LAST) begin
          out_data_d = stage_d;
          state_d    = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      wptr_q     <= '0;
      tptr_q     <= '0;
      in_reg_q   <= '0;
      stage_q    <= '0;
      out_data_q <= '0;
      weight_q   <= '{default: '0};
      thr_q      <= '{default: THR_W'(THR_INIT)};
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      wptr_q     <= wptr_d;
      tptr_q     <= tptr_d;
      in_reg_q   <= in_reg_d;
      stage_q    <= stage_d;
      out_data_q <= out_data_d;
      weight_q   <= weight_d;
      thr_q      <= thr_d;
    end
  end
endmodule
